// File: rtl/scoreboard_register_file_pkg.sv
// Shared sizing and types for the scoreboarded register file.
package register_file_params;

  localparam int REGISTER_SIZE             = 32;
  localparam int OPERAND_WIDTH             = 32;
  localparam int REGISTER_DESCRIPTOR_WIDTH = $clog2(REGISTER_SIZE);
  localparam int PENDING_WIDTH             = 2;

  typedef logic [REGISTER_DESCRIPTOR_WIDTH-1:0] register_descriptor_t;
  typedef logic [OPERAND_WIDTH-1:0]             operand_t;
  typedef logic [PENDING_WIDTH-1:0]             pending_count_t;

endpackage

// File: rtl/scoreboard_register_file_cell.sv
// One architectural register with its saturating pending-write counter.
// An error pulse is raised when more write-backs arrive than writes are outstanding.
module pending_register_cell
  import register_file_params::*;
#(
  parameter int CELL_WIDTH   = OPERAND_WIDTH,
  parameter int COUNT_WIDTH  = PENDING_WIDTH,
  parameter int HIT_WIDTH    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reserve_hit,
  input  logic [HIT_WIDTH-1:0]   wb_hit_count,
  input  logic [CELL_WIDTH-1:0]  wb_data,
  output logic [CELL_WIDTH-1:0]  data,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   error_pulse
);

  localparam int SUM_WIDTH = ((COUNT_WIDTH > HIT_WIDTH) ? COUNT_WIDTH : HIT_WIDTH) + 1;

  logic [SUM_WIDTH-1:0]   avail_s;
  logic [SUM_WIDTH-1:0]   hits_s;
  logic [COUNT_WIDTH-1:0] count_next_s;

  // Next pending count; too many write-backs floor the count at zero and flag an error.
  always_comb begin
    avail_s      = SUM_WIDTH'(count) + SUM_WIDTH'(reserve_hit);
    hits_s       = SUM_WIDTH'(wb_hit_count);
    count_next_s = '0;
    error_pulse  = 1'b0;
    if (hits_s > avail_s) begin
      count_next_s = '0;
      error_pulse  = 1'b1;
    end else begin
      count_next_s = COUNT_WIDTH'(avail_s - hits_s);
      error_pulse  = 1'b0;
    end
  end

  // Data and counter state; data is taken even on an erroneous write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      count <= '0;
    end else begin
      count <= count_next_s;
      if (wb_hit_count != '0) begin
        data <= wb_data;
      end else begin
        data <= data;
      end
    end
  end

endmodule

// File: rtl/scoreboard_register_file.sv
// Multi-port register file with per-register pending-write scoreboard; r0 reads as zero.
// Optional same-cycle write-to-read bypass: SCOREBOARD_REGISTER_FILE_WRITE_BYPASS_EN.
module scoreboard_register_file
  import register_file_params::*;
#(
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int REGISTER_SIZE   = register_file_params::REGISTER_SIZE,
  parameter int OPERAND_WIDTH   = register_file_params::OPERAND_WIDTH,
  parameter int PENDING_WIDTH   = register_file_params::PENDING_WIDTH
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [NUM_READ_PORTS-1:0][$clog2(REGISTER_SIZE)-1:0]  read_register_input,
  output logic [NUM_READ_PORTS-1:0][OPERAND_WIDTH-1:0]          read_data_output,
  output logic [NUM_READ_PORTS-1:0]                             read_reserved_output,
  input  logic                                                  reserve_input,
  input  logic [$clog2(REGISTER_SIZE)-1:0]                      reserve_register_input,
  output logic                                                  reserve_ready_output,
  input  logic [NUM_WRITE_PORTS-1:0]                            write_back_input,
  input  logic [NUM_WRITE_PORTS-1:0][$clog2(REGISTER_SIZE)-1:0] write_back_register_input,
  input  logic [NUM_WRITE_PORTS-1:0][OPERAND_WIDTH-1:0]         write_back_data_input,
  output logic                                                  write_back_error_output
);

  localparam int DW = $clog2(REGISTER_SIZE);
  localparam int HW = $clog2(NUM_WRITE_PORTS + 1);
  localparam logic [PENDING_WIDTH-1:0] COUNT_MAX = '1;

  logic [OPERAND_WIDTH-1:0] reg_data_s    [REGISTER_SIZE];
  logic [PENDING_WIDTH-1:0] reg_count_s   [REGISTER_SIZE];
  logic [HW-1:0]            wb_hits_s     [REGISTER_SIZE];
  logic [OPERAND_WIDTH-1:0] wb_sel_data_s [REGISTER_SIZE];
  logic [REGISTER_SIZE-1:0] reserve_hit_s;
  logic [REGISTER_SIZE-1:0] error_pulse_s;
  logic                     reserve_ready_s;
  logic                     error_r;

  // Per-register write-back hit count; the highest-indexed hitting port supplies the data.
  always_comb begin
    for (int r = 0; r < REGISTER_SIZE; r++) begin
      wb_hits_s[r]     = '0;
      wb_sel_data_s[r] = '0;
      for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
        if (r != 0 && write_back_input[p] && write_back_register_input[p] == DW'(r)) begin
          wb_hits_s[r]     = wb_hits_s[r] + HW'(1);
          wb_sel_data_s[r] = write_back_data_input[p];
        end else begin
          wb_hits_s[r]     = wb_hits_s[r];
          wb_sel_data_s[r] = wb_sel_data_s[r];
        end
      end
    end
  end

  // Reservation back-pressure: only a full counter with no draining write-back stalls issue.
  always_comb begin
    reserve_ready_s = 1'b1;
    if (reserve_register_input != '0
        && reg_count_s[reserve_register_input] == COUNT_MAX
        && wb_hits_s[reserve_register_input] == '0) begin
      reserve_ready_s = 1'b0;
    end else begin
      reserve_ready_s = 1'b1;
    end
  end

  assign reserve_ready_output = reserve_ready_s;

  // Decode the accepted reservation to a one-hot register hit.
  always_comb begin
    reserve_hit_s = '0;
    for (int r = 1; r < REGISTER_SIZE; r++) begin
      reserve_hit_s[r] = reserve_input && reserve_ready_s
                         && (reserve_register_input == DW'(r));
    end
  end

  assign reg_data_s[0]    = '0;
  assign reg_count_s[0]   = '0;
  assign error_pulse_s[0] = 1'b0;

  for (genvar g = 1; g < REGISTER_SIZE; g++) begin : g_cell
    pending_register_cell #(
      .CELL_WIDTH  (OPERAND_WIDTH),
      .COUNT_WIDTH (PENDING_WIDTH),
      .HIT_WIDTH   (HW)
    ) u_cell (
      .clk          (clk),
      .rst          (rst),
      .reserve_hit  (reserve_hit_s[g]),
      .wb_hit_count (wb_hits_s[g]),
      .wb_data      (wb_sel_data_s[g]),
      .data         (reg_data_s[g]),
      .count        (reg_count_s[g]),
      .error_pulse  (error_pulse_s[g])
    );
  end

  // Operand reads, optionally forwarding same-cycle write-back data.
  always_comb begin
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      read_data_output[p]     = reg_data_s[read_register_input[p]];
      read_reserved_output[p] = (reg_count_s[read_register_input[p]] != '0);
`ifdef SCOREBOARD_REGISTER_FILE_WRITE_BYPASS_EN
      if (wb_hits_s[read_register_input[p]] != '0) begin
        read_data_output[p] = wb_sel_data_s[read_register_input[p]];
      end else begin
        read_data_output[p] = reg_data_s[read_register_input[p]];
      end
      read_reserved_output[p] =
        ((PENDING_WIDTH + HW)'(reg_count_s[read_register_input[p]])
         > (PENDING_WIDTH + HW)'(wb_hits_s[read_register_input[p]]));
`endif
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      error_r <= 1'b0;
    end else if (|error_pulse_s) begin
      error_r <= 1'b1;
    end else begin
      error_r <= error_r;
    end
  end

  assign write_back_error_output = error_r;

endmodule
